// File: rtl/mesh_arb_pkg.sv
// Shared types and default sizes for the mesh terminal inject arbiter.
package mesh_arb_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned PCKG_SZ_DEF = 32;
  localparam int unsigned CNT_W_DEF   = 16;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_OFFER = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] w_j;

  // Scan from the farthest offset down so the nearest match wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    w_j   = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      w_j = IDX_W'((int'(ptr) + k) % int'(N));
      if (req[w_j]) begin
        valid = 1'b1;
        idx   = w_j;
      end
    end
  end

endmodule

// File: rtl/terminal_inject_arbiter.sv
// Round-robin arbiter feeding one mesh terminal input through a single holding register.
module terminal_inject_arbiter
  import mesh_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned pckg_sz = PCKG_SZ_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_pndng,
  input  logic [NUM_REQ-1:0][pckg_sz-1:0]  req_data,
  output logic [NUM_REQ-1:0]               req_pop,
  input  logic [NUM_REQ-1:0]               req_mask,
  output logic                             pndng,
  output logic [pckg_sz-1:0]               data_out,
  input  logic                             popin,
  output logic [$clog2(NUM_REQ)-1:0]       grant_id,
  output logic [CNT_W-1:0]                 pkt_cnt,
  output logic                             proto_err
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [pckg_sz-1:0] r_hold;
  logic [IDX_W-1:0]   r_grant_id;
  logic [CNT_W-1:0]   r_pkt_cnt;
  logic               r_proto_err;

  logic [NUM_REQ-1:0] w_elig;
  logic               w_valid;
  logic [IDX_W-1:0]   w_idx;
  logic [NUM_REQ-1:0] w_pop;
  logic               w_win;
  logic               w_deliver;
  logic               w_stray_pop;

  assign w_elig = req_pndng & req_mask;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (w_elig),
    .ptr   (r_rr_ptr),
    .valid (w_valid),
    .idx   (w_idx)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ARB_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state plus grant/deliver strobes; a full holding register blocks arbitration.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = '0;
    w_win       = 1'b0;
    w_deliver   = 1'b0;
    w_stray_pop = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        w_stray_pop = popin;
        if (w_valid) begin
          w_win        = 1'b1;
          w_pop[w_idx] = 1'b1;
          w_state_nxt  = ARB_OFFER;
        end
      end
      ARB_OFFER: begin
        if (popin) begin
          w_deliver   = 1'b1;
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // Capture winner, advance pointer, count deliveries, latch stray pops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr    <= '0;
      r_hold      <= '0;
      r_grant_id  <= '0;
      r_pkt_cnt   <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_win) begin
        r_hold     <= req_data[w_idx];
        r_grant_id <= w_idx;
        r_rr_ptr   <= IDX_W'((int'(w_idx) + 1) % int'(NUM_REQ));
      end
      if (w_deliver)   r_pkt_cnt   <= r_pkt_cnt + CNT_W'(1);
      if (w_stray_pop) r_proto_err <= 1'b1;
    end
  end

  // Reset masks the combinational handshake outputs immediately.
  assign req_pop   = reset ? '0 : w_pop;
  assign pndng     = (r_state == ARB_OFFER) && !reset;
  assign data_out  = r_hold;
  assign grant_id  = r_grant_id;
  assign pkt_cnt   = r_pkt_cnt;
  assign proto_err = r_proto_err;

endmodule

// File: doc/terminal_inject_arbiter.md
TERMINAL_INJECT_ARBITER -- requirements
Module: terminal_inject_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters sharing one mesh terminal input.
REQ-002 The block SHALL have parameter pckg_sz, default 32: packet width in bits.
REQ-003 The block SHALL have parameter CNT_W, default 16: width of the per-block packet counter.
REQ-004 Port clk  input  1  single clock; all logic on posedge clk.
REQ-005 Port reset  input  1  reset, synchronous and active-high.
REQ-006 Port req_pndng  input  [NUM_REQ]  requester i holds a packet.
REQ-007 Port req_data  input  [NUM_REQ][pckg_sz]  packet of requester i, stable while req_pndng[i]=1.
REQ-008 Port req_pop  output  [NUM_REQ]  one-cycle pop acknowledging requester i.
REQ-009 Port req_mask  input  [NUM_REQ]  1 = requester i eligible; 0 = never granted.
REQ-010 Port pndng  output  1  packet offered to mesh terminal.
REQ-011 Port data_out  output  [pckg_sz]  offered packet.
REQ-012 Port popin  input  1  mesh terminal consumes offered packet.
REQ-013 Port grant_id  output  [$clog2(NUM_REQ)]  source index of packet currently or last offered.
REQ-014 Port pkt_cnt  output  [CNT_W]  packets delivered since reset.
REQ-015 Port proto_err  output  1  sticky protocol-error flag.

Function
REQ-016 The FSM SHALL have states ARB_IDLE (holding register empty) and ARB_OFFER (holding register full).
REQ-017 In ARB_IDLE, pndng SHALL be 0; in ARB_OFFER, pndng SHALL be 1.
REQ-018 In ARB_IDLE, the winner SHALL be the first index j = (rr_ptr + k) mod NUM_REQ, k = 0..NUM_REQ-1, with req_pndng[j] & req_mask[j].
REQ-019 In ARB_IDLE with a winner, req_pop[winner] SHALL be 1 combinationally in that cycle; all other req_pop bits SHALL be 0.
REQ-020 req_pop[i] SHALL never be 1 unless req_pndng[i]=1, req_mask[i]=1 and state=ARB_IDLE; at most one bit SHALL be set.
REQ-021 At the edge ending a winning ARB_IDLE cycle: holding register <= req_data[winner], grant_id <= winner, rr_ptr <= (winner+1) mod NUM_REQ, state <= ARB_OFFER.
REQ-022 In ARB_OFFER, data_out SHALL equal the holding register and SHALL NOT change until the cycle after popin.
REQ-023 In ARB_OFFER with popin=1 at an edge: state <= ARB_IDLE, pkt_cnt <= pkt_cnt+1 (wraps modulo 2^CNT_W).
REQ-024 After a popin, pndng SHALL be 0 for at least one cycle; back-to-back offers without an ARB_IDLE cycle are forbidden. Sustained throughput is 1 packet per 2 cycles.
REQ-025 In ARB_OFFER, req_pndng activity SHALL be ignored and rr_ptr SHALL hold.
REQ-026 popin=1 while in ARB_IDLE SHALL be ignored for data, SHALL NOT change pkt_cnt, and SHALL set proto_err at the next edge.
REQ-027 proto_err SHALL remain 1 until reset.
REQ-028 A mask change SHALL take effect on the next ARB_IDLE arbitration and SHALL NOT affect a packet already in ARB_OFFER.
REQ-029 If no eligible request exists in ARB_IDLE, state and rr_ptr SHALL hold.

Reset
REQ-030 When reset=1 at an edge: state <= ARB_IDLE, rr_ptr <= 0, holding register <= 0, grant_id <= 0, pkt_cnt <= 0, proto_err <= 0.
REQ-031 While reset=1, req_pop SHALL be all 0 and pndng SHALL be 0.
REQ-032 A reset asserted in ARB_OFFER SHALL discard the held packet with no count.

Structure
REQ-033 The shared package mesh_arb_pkg SHALL hold the arb_state_t enum (ARB_IDLE, ARB_OFFER) and the default NUM_REQ, pckg_sz and CNT_W constants.
REQ-034 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req vector and rr_ptr; outputs valid and index), instantiated once.

Verification
REQ-035 Single request: mask=4'hF, req_pndng[2]=1, data 32'hCAFE0002 -> req_pop[2] for one cycle, then pndng=1, data_out=32'hCAFE0002, grant_id=2; popin -> pkt_cnt=1, pndng=0 the next cycle.
REQ-036 All four requesting continuously, popin tied high in ARB_OFFER -> grant order 0,1,2,3,0; one packet every 2 cycles; pkt_cnt=5 after five offers.
REQ-037 Masking: mask=4'b1010, all requesting -> only indices 1 and 3 are granted, alternating.
REQ-038 Stall: popin held 0 for 10 cycles in ARB_OFFER while req_data changes -> data_out and pndng stay constant and no req_pop is asserted.
REQ-039 Protocol error: popin=1 in ARB_IDLE -> proto_err=1 from the next cycle until reset, and pkt_cnt is unchanged.
REQ-040 Reset mid-offer: reset in ARB_OFFER -> next cycle pndng=0, pkt_cnt=0, proto_err=0; the next grant starts from index 0.
